data_memory_ls: RTL and testbench

Next-generation data memory for the RISC-V datapath. It adds byte, halfword and word load/store (RV32I funct3 encoding), byte addressing with little-endian lanes, and a valid/ready request handshake. Read latency is configurable and responses are flagged. It sits in the MEM stage between the ALU address output and the write-back mux. It replaces the single-cycle word-only memory.

---
 rtl/data_memory_ls.sv | 176 +++++++++++++++++
 tb/tb_data_memory_ls.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ls.sv
// data_memory_ls: byte-addressed RV32 data memory with B/H/W load/store,
// valid/ready request handshake and configurable response latency.
`default_nettype none

module data_memory_ls #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rsp_valid,
    output logic              o_err
);

    localparam int         c_DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);
    localparam bit         c_SINGLE   = (LATENCY == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_store;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_idle;
    logic              w_accept;
    logic              w_enter_resp;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_funct3;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_store;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_err;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wword;
    logic [DATA_W-1:0] w_rd_next;
    logic              w_we;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && i_req_valid && (i_mem_read || i_mem_write);

    // With LATENCY=1 the memory access happens on the accept edge itself,
    // so the live request inputs stand in for the not-yet-latched copies.
    assign w_addr    = w_idle ? i_addr      : r_addr;
    assign w_funct3  = w_idle ? i_funct3    : r_funct3;
    assign w_wr_data = w_idle ? i_wr_data   : r_wr_data;
    assign w_store   = w_idle ? i_mem_write : r_store;

    assign w_enter_resp = (c_SINGLE && w_accept) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_word = r_mem[w_addr[ADDR_W-1:2]];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_err     = 1'b0;
        w_be      = 4'b0000;
        w_wword   = w_wr_data;
        w_rd_next = '0;
        case (w_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wword = {4{w_wr_data[7:0]}};
            end
            2'b01: begin
                w_err   = w_addr[0];
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{w_wr_data[15:0]}};
            end
            2'b10: begin
                w_err = (w_addr[1:0] != 2'b00);
                w_be  = 4'b1111;
            end
            default: w_err = 1'b1;
        endcase
        if (w_store && w_funct3[2])
            w_err = 1'b1;
        if (!w_store && (w_funct3 == 3'b110))
            w_err = 1'b1;
        if (!w_err && !w_store) begin
            case (w_funct3)
                3'b000:  w_rd_next = {{24{w_byte[7]}}, w_byte};
                3'b001:  w_rd_next = {{16{w_half[15]}}, w_half};
                3'b100:  w_rd_next = {24'd0, w_byte};
                3'b101:  w_rd_next = {16'd0, w_half};
                default: w_rd_next = w_word;
            endcase
        end
    end

    // Gating with i_rst_n keeps an aborted store from landing while reset is held.
    assign w_we = w_enter_resp && w_store && !w_err && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_addr[ADDR_W-1:2]][i*8 +: 8] <= w_wword[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_funct3  <= 3'd0;
            r_wr_data <= '0;
            r_store   <= 1'b0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= i_addr;
                        r_funct3  <= i_funct3;
                        r_wr_data <= i_wr_data;
                        r_store   <= i_mem_write;
                        r_cnt     <= c_CNT_INIT;
                        r_state   <= c_SINGLE ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0)
                        r_state <= S_RESP;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rd_data <= w_rd_next;
                r_err     <= w_err;
            end
        end
    end

    assign o_req_ready = w_idle;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_err       = r_err && (r_state == S_RESP);
    assign o_rd_data   = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ls.sv
// tb_data_memory_ls: scoreboard bench for data_memory_ls at LATENCY=1 and LATENCY=4.
`default_nettype none

module tb_data_memory_ls;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [9:0]  addr = '0;
    logic [31:0] wr_data = '0;

    logic        ready1, rsp1, err1, ready4, rsp4, err4;
    logic [31:0] rd1, rd4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    data_memory_ls #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(ready1),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd1),
        .o_rsp_valid(rsp1), .o_err(err1)
    );

    data_memory_ls #(.ADDR_W(10), .DATA_W(32), .LATENCY(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v4), .o_req_ready(ready4),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd4),
        .o_rsp_valid(rsp4), .o_err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel4, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [9:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wr_data   = d;
        if (sel4) v4 = 1'b1; else v1 = 1'b1;
    endtask

    task automatic do_req(input string tag, input bit sel4, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_e);
        int n;
        logic [32:0] e;
        @(negedge clk);
        drive(sel4, rd, wr, f3, a, d);
        q.push_back({exp_e, exp_d});
        @(negedge clk);
        v1 = 1'b0;
        v4 = 1'b0;
        n = 1;
        while (!(sel4 ? rsp4 : rsp1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp"}, 32'(sel4 ? rsp4 : rsp1), 32'd1);
        chk({tag, "_lat"}, 32'(n), sel4 ? 32'd5 : 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_data"}, sel4 ? rd4 : rd1, e[31:0]);
            chk({tag, "_err"}, 32'(sel4 ? err4 : err1), 32'(e[32]));
        end
        @(negedge clk);
        chk({tag, "_hold"}, sel4 ? rd4 : rd1, exp_d);
        chk({tag, "_pulse"}, 32'(sel4 ? rsp4 : rsp1), 32'd0);
    endtask

    initial begin
        int low_cnt, rsp_cnt, lat;
        logic [32:0] e;

        repeat (3) @(negedge clk);
        chk("rst_ready", {30'd0, ready1, ready4}, 32'd3);
        chk("rst_rsp",   {30'd0, rsp1, rsp4}, 32'd0);
        chk("rst_err",   {30'd0, err1, err4}, 32'd0);
        chk("rst_rd",    rd1 | rd4, 32'd0);
        rst_n = 1'b1;

        // word / byte / halfword traffic at LATENCY=1
        do_req("sw010",  0, 0, 1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 0);
        do_req("lw010",  0, 1, 0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 0);
        do_req("lb010",  0, 1, 0, 3'b000, 10'h010, 32'h0, 32'hFFFFFFEF, 0);
        do_req("lh010",  0, 1, 0, 3'b001, 10'h010, 32'h0, 32'hFFFFBEEF, 0);
        do_req("lbu011", 0, 1, 0, 3'b100, 10'h011, 32'h0, 32'h000000BE, 0);
        do_req("sb013",  0, 0, 1, 3'b000, 10'h013, 32'h000000A5, 32'h0, 0);
        do_req("lb013",  0, 1, 0, 3'b000, 10'h013, 32'h0, 32'hFFFFFFA5, 0);
        do_req("lbu013", 0, 1, 0, 3'b100, 10'h013, 32'h0, 32'h000000A5, 0);
        do_req("lw010b", 0, 1, 0, 3'b010, 10'h010, 32'h0, 32'hA5ADBEEF, 0);
        do_req("lh012",  0, 1, 0, 3'b001, 10'h012, 32'h0, 32'hFFFFA5AD, 0);
        do_req("sw020",  0, 0, 1, 3'b010, 10'h020, 32'h11223344, 32'h0, 0);
        do_req("sh022",  0, 0, 1, 3'b001, 10'h022, 32'h00008001, 32'h0, 0);
        do_req("lh022",  0, 1, 0, 3'b001, 10'h022, 32'h0, 32'hFFFF8001, 0);
        do_req("lhu022", 0, 1, 0, 3'b101, 10'h022, 32'h0, 32'h00008001, 0);
        do_req("lw020",  0, 1, 0, 3'b010, 10'h020, 32'h0, 32'h80013344, 0);

        // error cases: misaligned, illegal funct3; memory must stay intact
        do_req("lw011e", 0, 1, 0, 3'b010, 10'h011, 32'h0, 32'h0, 1);
        do_req("sh021e", 0, 0, 1, 3'b001, 10'h021, 32'hFFFFFFFF, 32'h0, 1);
        do_req("ld011e", 0, 1, 0, 3'b011, 10'h020, 32'h0, 32'h0, 1);
        do_req("sb1xxe", 0, 0, 1, 3'b100, 10'h020, 32'h000000FF, 32'h0, 1);
        do_req("lw020c", 0, 1, 0, 3'b010, 10'h020, 32'h0, 32'h80013344, 0);

        // valid without an op is ignored
        @(negedge clk);
        drive(0, 0, 0, 3'b010, 10'h020, 32'h0);
        rsp_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp1) rsp_cnt++;
        end
        v1 = 1'b0;
        chk("noop_rsp", 32'(rsp_cnt), 32'd0);
        chk("noop_ready", 32'(ready1), 32'd1);

        // LATENCY=4 with Req_valid held high through the access
        @(negedge clk);
        drive(1, 0, 1, 3'b010, 10'h040, 32'h0BADF00D);
        q.push_back({1'b0, 32'h0});
        low_cnt = 0; rsp_cnt = 0; lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!ready4) low_cnt++;
            if (rsp4) begin
                rsp_cnt++;
                lat = k;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("hold_data", rd4, e[31:0]);
                    chk("hold_err", 32'(err4), 32'(e[32]));
                end
                v4 = 1'b0;
            end
        end
        v4 = 1'b0;
        chk("hold_low", 32'(low_cnt), 32'd5);
        chk("hold_lat", 32'(lat), 32'd5);
        chk("hold_rspcnt", 32'(rsp_cnt), 32'd1);
        chk("hold_ready", 32'(ready4), 32'd1);
        do_req("lw040", 1, 1, 0, 3'b010, 10'h040, 32'h0, 32'h0BADF00D, 0);

        // reset in the second WAIT cycle aborts a pending store
        do_req("sw030", 1, 0, 1, 3'b010, 10'h030, 32'hCAFEF00D, 32'h0, 0);
        do_req("lw030", 1, 1, 0, 3'b010, 10'h030, 32'h0, 32'hCAFEF00D, 0);
        @(negedge clk);
        drive(1, 0, 1, 3'b010, 10'h030, 32'h12345678);
        @(negedge clk);
        v4 = 1'b0;
        chk("abort_wait", 32'(ready4), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready4), 32'd1);
        chk("abort_rsp", 32'(rsp4), 32'd0);
        chk("abort_err", 32'(err4), 32'd0);
        chk("abort_rd", rd4, 32'd0);
        rsp_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp4) rsp_cnt++;
        end
        rst_n = 1'b1;
        chk("abort_norsp", 32'(rsp_cnt), 32'd0);
        do_req("lw030b", 1, 1, 0, 3'b010, 10'h030, 32'h0, 32'hCAFEF00D, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
